// File: rtl/c1_pkg.sv
// Shared definitions for the C1 CPU<->cache bus responder: command codes, FSM states, line geometry.
package c1_pkg;

  typedef enum logic [2:0] {
    CmdNop  = 3'd0,
    CmdRd8  = 3'd1,
    CmdRd16 = 3'd2,
    CmdRd32 = 3'd3,
    CmdInv  = 3'd4,
    CmdWr8  = 3'd5,
    CmdWr16 = 3'd6,
    CmdWr32 = 3'd7
  } c1_cmd_e;

  // The responder answers with the same code the initiator uses for WR32.
  localparam logic [2:0] C1_RESP = 3'd7;

  typedef logic [2:0] c1_state_t;
  localparam c1_state_t StIdle   = 3'd0;
  localparam c1_state_t StAddrB  = 3'd1;
  localparam c1_state_t StWait   = 3'd2;
  localparam c1_state_t StResp   = 3'd3;
  localparam c1_state_t StRespHi = 3'd4;

  localparam int unsigned C1_LINE_BYTES = 16;
  localparam int unsigned C1_OFF_W      = 4;

endpackage

// File: rtl/c1_byte_store.sv
// Byte store for the C1 responder: 4-byte combinational read and up-to-4-byte write, both wrapping
// within a 16-byte line, plus a whole-line clear strobe. Contents are deliberately not reset.
module c1_byte_store
  import c1_pkg::*;
#(
  parameter int unsigned STORE_ADDR_SIZE = 12
) (
  input  logic                                clk,
  input  logic [STORE_ADDR_SIZE-C1_OFF_W-1:0] line,
  input  logic [C1_OFF_W-1:0]                 off,
  output logic [31:0]                         rd_word,
  input  logic [3:0]                          wr_be,
  input  logic [31:0]                         wr_word,
  input  logic                                clr_line
);

  logic [7:0] mem [2**STORE_ADDR_SIZE];

  // off + k is kept at offset width so byte lanes wrap inside the line.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 4; k++) begin
      rd_word[8*k +: 8] = mem[{line, off + C1_OFF_W'(k)}];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_line) begin
      for (int j = 0; j < C1_LINE_BYTES; j++) begin
        mem[{line, C1_OFF_W'(j)}] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) begin
          mem[{line, off + C1_OFF_W'(k)}] <= wr_word[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/c1_bus_responder.sv
// Responder end of the C1 CPU<->cache bus: decodes the two-cycle address phase, services reads,
// writes and INV against c1_byte_store, and answers with RESP. Define C1_INV_CLEAR_EN to make INV
// zero the addressed line; otherwise INV is acknowledged only.
module c1_bus_responder
  import c1_pkg::*;
#(
  parameter int unsigned MEM_ADDR_SIZE     = 19,
  parameter int unsigned BUS_SIZE          = 16,
  parameter int unsigned CACHE_OFFSET_SIZE = 4,
  parameter int unsigned STORE_ADDR_SIZE   = 12,
  parameter int unsigned RESP_DELAY        = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
  inout  wire  [BUS_SIZE-1:0]                      data,
  inout  wire  [2:0]                               command
);

  localparam int unsigned LineW = STORE_ADDR_SIZE - C1_OFF_W;
  localparam int unsigned AddrW = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;

  c1_state_t             state_q, state_d;
  c1_cmd_e               cmd_q, cmd_d;
  logic [LineW-1:0]      line_q, line_d;
  logic [C1_OFF_W-1:0]   off_q, off_d;
  logic [BUS_SIZE-1:0]   data_lo_q, data_lo_d;
  logic [BUS_SIZE-1:0]   data_hi_q, data_hi_d;
  logic [3:0]            cnt_q, cnt_d;

  logic                  cmd_start;
  logic                  commit;
  logic [3:0]            wr_be;
  logic                  clr_line;
  logic [31:0]           rd_word;
  logic [BUS_SIZE-1:0]   rd_bus;
  logic                  drive_cmd;
  logic                  drive_data;

  // Upper tag bits alias onto the same store lines.
  logic unused_addr;
  assign unused_addr = ^address[AddrW-1:LineW];

  // Explicit value list so NOP, z and X all fail to start a transaction.
  always_comb begin
    case (command)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7: cmd_start = 1'b1;
      default:                                  cmd_start = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    line_d    = line_q;
    off_d     = off_q;
    data_lo_d = data_lo_q;
    data_hi_d = data_hi_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle: begin
        if (cmd_start) begin
          state_d   = StAddrB;
          cmd_d     = c1_cmd_e'(command);
          line_d    = address[LineW-1:0];
          data_lo_d = data;
        end
      end
      StAddrB: begin
        state_d   = StWait;
        off_d     = address[C1_OFF_W-1:0];
        data_hi_d = data;
        cnt_d     = 4'(RESP_DELAY - 1);
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:   state_d = (cmd_q == CmdRd32) ? StRespHi : StIdle;
      StRespHi: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cmd_q     <= CmdNop;
      line_q    <= '0;
      off_q     <= '0;
      data_lo_q <= '0;
      data_hi_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      line_q    <= line_d;
      off_q     <= off_d;
      data_lo_q <= data_lo_d;
      data_hi_q <= data_hi_d;
      cnt_q     <= cnt_d;
    end
  end

  // Side effects land on the clock edge that enters RESP.
  assign commit = (state_q == StWait) && (cnt_q == 4'd0);

  always_comb begin
    wr_be = 4'b0000;
    if (commit) begin
      case (cmd_q)
        CmdWr8:  wr_be = 4'b0001;
        CmdWr16: wr_be = 4'b0011;
        CmdWr32: wr_be = 4'b1111;
        default: wr_be = 4'b0000;
      endcase
    end
  end

`ifdef C1_INV_CLEAR_EN
  assign clr_line = commit && (cmd_q == CmdInv);
`else
  assign clr_line = 1'b0;
`endif

  c1_byte_store #(
    .STORE_ADDR_SIZE(STORE_ADDR_SIZE)
  ) u_store (
    .clk      (clk),
    .line     (line_q),
    .off      (off_q),
    .rd_word  (rd_word),
    .wr_be    (wr_be),
    .wr_word  ({data_hi_q, data_lo_q}),
    .clr_line (clr_line)
  );

  always_comb begin
    if (state_q == StRespHi)  rd_bus = rd_word[31:16];
    else if (cmd_q == CmdRd8) rd_bus = {8'h00, rd_word[7:0]};
    else                      rd_bus = rd_word[15:0];
  end

  assign drive_cmd  = (state_q == StResp) || (state_q == StRespHi);
  assign drive_data = drive_cmd &&
                      ((cmd_q == CmdRd8) || (cmd_q == CmdRd16) || (cmd_q == CmdRd32));

  assign command = drive_cmd  ? C1_RESP : 3'bzzz;
  assign data    = drive_data ? rd_bus  : {BUS_SIZE{1'bz}};

endmodule

// File: tb/tb_c1_bus_responder.sv
// Directed self-checking bench for c1_bus_responder; the initiator drives on negedge and samples
// on negedge. Weak pulldowns make a released bus read as zero.
module tb_c1_bus_responder;

  localparam int unsigned RespDelay = 2;

  localparam logic [18:0] A14   = 19'b0000000000_01110_0000;
  localparam logic [18:0] A14_1 = 19'b0000000000_01110_0001;
  localparam logic [18:0] A14_F = 19'b0000000000_01110_1111;
  localparam logic [18:0] A46   = 19'b0000000001_01110_0000;
  localparam logic [18:0] A15   = 19'b0000000000_01111_0000;
  localparam logic [18:0] A17   = 19'b0000000000_10001_0000;

  logic        clk;
  logic        rst_n;
  logic [14:0] address;
  wire  [15:0] data;
  wire  [2:0]  command;

  logic [15:0] tb_data;
  logic        tb_data_en;
  logic [2:0]  tb_cmd;
  logic        tb_cmd_en;

  int n_checks;
  int n_errors;

  assign data    = tb_data_en ? tb_data : 16'hzzzz;
  assign command = tb_cmd_en  ? tb_cmd  : 3'bzzz;

  for (genvar i = 0; i < 3; i++) begin : g_pd_cmd
    pulldown (command[i]);
  end
  for (genvar i = 0; i < 16; i++) begin : g_pd_data
    pulldown (data[i]);
  end

  c1_bus_responder #(
    .MEM_ADDR_SIZE     (19),
    .BUS_SIZE          (16),
    .CACHE_OFFSET_SIZE (4),
    .STORE_ADDR_SIZE   (12),
    .RESP_DELAY        (RespDelay)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .data    (data),
    .command (command)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Cycles A and B; returns at the negedge after cycle B with both buses released.
  task automatic start_txn(input logic [2:0] cmd, input logic [18:0] a, input logic [31:0] w);
    tb_cmd     = cmd;
    tb_cmd_en  = 1'b1;
    address    = a[18:4];
    tb_data    = w[15:0];
    tb_data_en = 1'b1;
    @(negedge clk);
    tb_cmd_en  = 1'b0;
    address    = {11'd0, a[3:0]};
    tb_data    = w[31:16];
    @(negedge clk);
    tb_data_en = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    while (command !== 3'd7 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, RespDelay);
  endtask

  task automatic finish_txn(input string tag, input bit is_rd, input bit is_rd32,
                            input logic [15:0] exp_lo, input logic [15:0] exp_hi);
    wait_resp(tag);
    if (is_rd) check({tag, "_lo"}, data, exp_lo);
    if (is_rd32) begin
      @(negedge clk);
      check({tag, "_cmd_hi"}, command, 3'd7);
      check({tag, "_hi"}, data, exp_hi);
    end
    @(negedge clk);
    check({tag, "_rel"}, {command, data}, 19'd0);
  endtask

  task automatic do_wr(input string tag, input logic [2:0] cmd, input logic [18:0] a,
                       input logic [31:0] w);
    start_txn(cmd, a, w);
    finish_txn(tag, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_rd(input string tag, input logic [2:0] cmd, input logic [18:0] a,
                       input logic [15:0] exp_lo, input logic [15:0] exp_hi);
    start_txn(cmd, a, 32'h0);
    finish_txn(tag, 1'b1, cmd == 3'd3, exp_lo, exp_hi);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    address    = '0;
    tb_data    = '0;
    tb_data_en = 1'b0;
    tb_cmd     = '0;
    tb_cmd_en  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd", command, 3'd0);
    check("rst_data", data, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    do_wr("wr8", 3'd5, A14, 32'h0000_00F0);
    do_rd("rd8", 3'd1, A14, 16'h00F0, 16'h0);

    do_wr("wr16", 3'd6, A14, 32'h0000_FF00);
    do_rd("rd16", 3'd2, A14, 16'hFF00, 16'h0);
    do_rd("rd8_off1", 3'd1, A14_1, 16'h00FF, 16'h0);

    // Reset while the responder is driving RESP.
    start_txn(3'd2, A14, 32'h0);
    wait_resp("rst_resp");
    rst_n = 1'b0;
    #1;
    check("rst_mid_cmd", command, 3'd0);
    check("rst_mid_data", data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_wr("wr32", 3'd7, A14, 32'hF0F0_0F0F);
    do_rd("rd32", 3'd3, A14, 16'h0F0F, 16'hF0F0);
    do_wr("wr32_l46", 3'd7, A46, 32'hFFFF_0FF0);
    do_rd("rd32_l46", 3'd3, A46, 16'h0FF0, 16'hFFFF);
    do_rd("rd32_l14", 3'd3, A14, 16'h0F0F, 16'hF0F0);

    do_wr("wr8_l15", 3'd5, A15, 32'h0000_005A);
    do_wr("wr16_wrap", 3'd6, A14_F, 32'h0000_ABCD);
    do_rd("rd8_offF", 3'd1, A14_F, 16'h00CD, 16'h0);
    do_rd("rd8_off0", 3'd1, A14, 16'h00AB, 16'h0);
    do_rd("rd8_l15", 3'd1, A15, 16'h005A, 16'h0);
    do_rd("rd32_wrap", 3'd3, A14_F, 16'hABCD, 16'hF00F);

    // Reset during WAIT drops the pending write.
    start_txn(3'd5, A15, 32'h0000_0077);
    rst_n = 1'b0;
    #1;
    check("rst_wait_cmd", command, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_rd("rd8_dropped", 3'd1, A15, 16'h005A, 16'h0);

    do_wr("wr32_l17", 3'd7, A17, 32'h5555_5555);
    do_wr("inv_l17", 3'd4, A17, 32'h0);
`ifdef C1_INV_CLEAR_EN
    do_rd("rd32_inv", 3'd3, A17, 16'h0000, 16'h0000);
`else
    do_rd("rd32_inv", 3'd3, A17, 16'h5555, 16'h5555);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
